// File: rtl/csr_access_ctrl.sv
// CSR access sequencer for the EX stage.
// Runs each CSR instruction as READ then WRITE, driving the CSR ALU in between.
// Shares the single CSR write port with the trap unit, which writes mepc and then mcause.
// All control and pulse outputs are registered; only csr_wdata and stall are combinational,
// because csr_wdata must carry the same-cycle ALU result or the held trap values.
module csr_access_ctrl #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_valid,
    input  logic [1:0]        ins_op,
    input  logic [ADDR_W-1:0] ins_addr,
    input  logic [XLEN-1:0]   ins_src,
    input  logic              ins_src_zero,
    output logic              ins_ready,
    output logic [XLEN-1:0]   rd_val,
    output logic              rd_valid,
    output logic              illegal,
    input  logic              trap_req,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic [XLEN-1:0]   trap_cause,
    output logic              trap_ack,
    output logic [ADDR_W-1:0] csr_raddr,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              csr_we,
    output logic [ADDR_W-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic [1:0]        alu_op,
    output logic [XLEN-1:0]   alu_csr,
    output logic [XLEN-1:0]   alu_rs1,
    input  logic [XLEN-1:0]   alu_res,
    output logic              stall
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WRITE   = 3'd2,
        T_EPC   = 3'd3,
        T_CAUSE = 3'd4
    } state_t;

    // Source selected onto csr_wdata during the cycle the write port is in use.
    typedef enum logic [1:0] {
        WSEL_NONE  = 2'd0,
        WSEL_ALU   = 2'd1,
        WSEL_EPC   = 2'd2,
        WSEL_CAUSE = 2'd3
    } wsel_t;

    localparam logic [1:0]        OP_NONE    = 2'b00;
    localparam logic [1:0]        OP_RW      = 2'b01;
    localparam logic [ADDR_W-1:0] ADDR_MEPC  = ADDR_W'(12'h341);
    localparam logic [ADDR_W-1:0] ADDR_MCAUS = ADDR_W'(12'h342);

    state_t            state;
    wsel_t             wsel;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   src_q;
    logic              src_zero_q;

    logic wr_intent;
    logic read_only;

    // RS/RC with a zero source only read; the top two address bits 11 mark read-only CSRs.
    assign wr_intent = (op_q == OP_RW) || !src_zero_q;
    assign read_only = (addr_q[ADDR_W-1 -: 2] == 2'b11);

    // Main sequencer: state, captured instruction and registered outputs for the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wsel       <= WSEL_NONE;
            addr_q     <= '0;
            op_q       <= OP_NONE;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            ins_ready  <= 1'b0;
            rd_valid   <= 1'b0;
            rd_val     <= '0;
            illegal    <= 1'b0;
            trap_ack   <= 1'b0;
            csr_raddr  <= '0;
            csr_we     <= 1'b0;
            csr_waddr  <= '0;
            alu_op     <= OP_NONE;
            alu_csr    <= '0;
            alu_rs1    <= '0;
        end else begin
            // Outputs are single-cycle unless the transition below re-asserts them.
            wsel      <= WSEL_NONE;
            ins_ready <= 1'b0;
            rd_valid  <= 1'b0;
            rd_val    <= '0;
            illegal   <= 1'b0;
            trap_ack  <= 1'b0;
            csr_raddr <= '0;
            csr_we    <= 1'b0;
            csr_waddr <= '0;
            alu_op    <= OP_NONE;
            alu_csr   <= '0;
            alu_rs1   <= '0;

            case (state)
                IDLE: begin
                    // A pending trap wins over an instruction presented in the same cycle.
                    if (trap_req) begin
                        state     <= T_EPC;
                        csr_we    <= 1'b1;
                        csr_waddr <= ADDR_MEPC;
                        wsel      <= WSEL_EPC;
                    end else if (ins_valid && (ins_op != OP_NONE)) begin
                        state      <= READ;
                        addr_q     <= ins_addr;
                        op_q       <= ins_op;
                        src_q      <= ins_src;
                        src_zero_q <= ins_src_zero;
                        csr_raddr  <= ins_addr;
                    end
                end
                READ: begin
                    // The old value read this cycle feeds both rd and the ALU in WRITE.
                    state     <= WRITE;
                    ins_ready <= 1'b1;
                    rd_valid  <= 1'b1;
                    rd_val    <= csr_rdata;
                    alu_op    <= op_q;
                    alu_csr   <= csr_rdata;
                    alu_rs1   <= src_q;
                    csr_waddr <= addr_q;
                    wsel      <= WSEL_ALU;
                    if (wr_intent && read_only) begin
                        illegal <= 1'b1;
                    end else begin
                        csr_we <= wr_intent;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                T_EPC: begin
                    state     <= T_CAUSE;
                    csr_we    <= 1'b1;
                    csr_waddr <= ADDR_MCAUS;
                    wsel      <= WSEL_CAUSE;
                    trap_ack  <= 1'b1;
                end
                T_CAUSE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write data mux: ALU result for instructions, held trap values for the trap writes.
    always_comb begin
        csr_wdata = '0;
        case (wsel)
            WSEL_ALU:   csr_wdata = alu_res;
            WSEL_EPC:   csr_wdata = trap_pc;
            WSEL_CAUSE: csr_wdata = trap_cause;
            default:    csr_wdata = '0;
        endcase
    end

    // EX is held while a real CSR instruction waits for retirement or any sequence is running.
    always_comb begin
        stall = (ins_valid && (ins_op != OP_NONE) && !ins_ready) || (state != IDLE);
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: directed vectors, a cycle-scheduled
// transaction model with its own CSR shadow, and literal expectations per scenario.
module tb_csr_access_ctrl;

    localparam int NCYC = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ins_valid = 1'b0;
    logic [1:0]  ins_op = 2'b00;
    logic [11:0] ins_addr = '0;
    logic [63:0] ins_src = '0;
    logic        ins_src_zero = 1'b0;
    logic        ins_ready;
    logic [63:0] rd_val;
    logic        rd_valid;
    logic        illegal;
    logic        trap_req = 1'b0;
    logic [63:0] trap_pc = '0;
    logic [63:0] trap_cause = '0;
    logic        trap_ack;
    logic [11:0] csr_raddr;
    logic [63:0] csr_rdata;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic [1:0]  alu_op;
    logic [63:0] alu_csr;
    logic [63:0] alu_rs1;
    logic [63:0] alu_res;
    logic        stall;

    csr_access_ctrl #(.XLEN(64), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_op(ins_op), .ins_addr(ins_addr),
        .ins_src(ins_src), .ins_src_zero(ins_src_zero),
        .ins_ready(ins_ready), .rd_val(rd_val), .rd_valid(rd_valid), .illegal(illegal),
        .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_ack(trap_ack),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .alu_op(alu_op), .alu_csr(alu_csr), .alu_rs1(alu_rs1), .alu_res(alu_res),
        .stall(stall)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // CSR semantics: RW replaces, RS sets bits, RC clears bits.
    function automatic logic [63:0] csr_alu(input logic [1:0] op, input logic [63:0] old,
                                            input logic [63:0] src);
        case (op)
            2'b01:   return src;
            2'b10:   return old | src;
            2'b11:   return old & ~src;
            default: return 64'h0;
        endcase
    endfunction

    // Environment: CSR file with same-cycle read, and the combinational CSR ALU.
    logic [63:0] env_mem [4096];
    logic [63:0] shadow  [4096];
    always_comb csr_rdata = env_mem[csr_raddr];
    always_comb alu_res = csr_alu(alu_op, alu_csr, alu_rs1);
    always @(posedge clk) if (csr_we) env_mem[csr_waddr] <= csr_wdata;

    task automatic setcsr(input logic [11:0] a, input logic [63:0] v);
        env_mem[a] = v;
        shadow[a]  = v;
    endtask

    // Model: per-cycle expected outputs, filled in when an access is accepted.
    logic        e_we [NCYC], e_ready [NCYC], e_ill [NCYC], e_ack [NCYC], e_busy [NCYC];
    logic [11:0] e_waddr [NCYC], e_raddr [NCYC];
    logic [63:0] e_wdata [NCYC], e_rd [NCYC], e_acsr [NCYC], e_ars1 [NCYC];
    logic [1:0]  e_aop [NCYC];
    int          cyc = 0;
    int          free_at = 0;
    logic [63:0] m_old;
    logic        m_wr, m_ro;

    task automatic clear_from(input int c);
        for (int i = c; i < NCYC; i++) begin
            e_we[i] = 0; e_ready[i] = 0; e_ill[i] = 0; e_ack[i] = 0; e_busy[i] = 0;
            e_waddr[i] = '0; e_raddr[i] = '0; e_wdata[i] = '0; e_rd[i] = '0;
            e_acsr[i] = '0; e_ars1[i] = '0; e_aop[i] = '0;
        end
    endtask

    always @(posedge clk) begin
        if (!rst && cyc + 3 < NCYC) begin
            if (e_we[cyc]) shadow[e_waddr[cyc]] = e_wdata[cyc];
            if (cyc >= free_at) begin
                if (trap_req) begin
                    e_busy[cyc+1] = 1; e_we[cyc+1] = 1; e_waddr[cyc+1] = 12'h341;
                    e_wdata[cyc+1] = trap_pc;
                    e_busy[cyc+2] = 1; e_we[cyc+2] = 1; e_waddr[cyc+2] = 12'h342;
                    e_wdata[cyc+2] = trap_cause; e_ack[cyc+2] = 1;
                    free_at = cyc + 3;
                end else if (ins_valid && ins_op != 2'b00) begin
                    m_old = shadow[ins_addr];
                    m_wr  = (ins_op == 2'b01) || !ins_src_zero;
                    m_ro  = (ins_addr[11:10] == 2'b11);
                    e_busy[cyc+1] = 1; e_raddr[cyc+1] = ins_addr;
                    e_busy[cyc+2] = 1; e_ready[cyc+2] = 1; e_rd[cyc+2] = m_old;
                    e_aop[cyc+2] = ins_op; e_acsr[cyc+2] = m_old; e_ars1[cyc+2] = ins_src;
                    e_ill[cyc+2] = m_wr && m_ro; e_we[cyc+2] = m_wr && !m_ro;
                    e_waddr[cyc+2] = ins_addr; e_wdata[cyc+2] = csr_alu(ins_op, m_old, ins_src);
                    free_at = cyc + 3;
                end
            end
        end
        cyc = cyc + 1;
    end

    // A reset drops everything still scheduled, including half-finished traps.
    always @(posedge rst) begin
        clear_from(cyc);
        free_at = 0;
    end

    // Compare process: every cycle, mid-cycle.
    always @(negedge clk) begin
        if (cyc < NCYC) begin
            chk($sformatf("c%0d ins_ready", cyc), 64'(ins_ready), 64'(e_ready[cyc]));
            chk($sformatf("c%0d rd_valid", cyc), 64'(rd_valid), 64'(e_ready[cyc]));
            chk($sformatf("c%0d rd_val", cyc), rd_val, e_rd[cyc]);
            chk($sformatf("c%0d illegal", cyc), 64'(illegal), 64'(e_ill[cyc]));
            chk($sformatf("c%0d trap_ack", cyc), 64'(trap_ack), 64'(e_ack[cyc]));
            chk($sformatf("c%0d csr_we", cyc), 64'(csr_we), 64'(e_we[cyc]));
            if (e_we[cyc]) begin
                chk($sformatf("c%0d csr_waddr", cyc), 64'(csr_waddr), 64'(e_waddr[cyc]));
                chk($sformatf("c%0d csr_wdata", cyc), csr_wdata, e_wdata[cyc]);
            end
            chk($sformatf("c%0d csr_raddr", cyc), 64'(csr_raddr), 64'(e_raddr[cyc]));
            chk($sformatf("c%0d alu_op", cyc), 64'(alu_op), 64'(e_aop[cyc]));
            chk($sformatf("c%0d alu_csr", cyc), alu_csr, e_acsr[cyc]);
            chk($sformatf("c%0d alu_rs1", cyc), alu_rs1, e_ars1[cyc]);
            chk($sformatf("c%0d stall", cyc), 64'(stall),
                64'(e_busy[cyc] || (ins_valid && ins_op != 2'b00 && !e_ready[cyc])));
        end
    end

    // Present one instruction, hold it until retirement (bounded), then release it.
    task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] src,
                         input logic zero, output int lat, output logic [63:0] rd,
                         output logic ill, output logic we, output logic [11:0] wa,
                         output logic [63:0] wd);
        @(posedge clk); #1;
        ins_valid = 1'b1; ins_op = op; ins_addr = addr; ins_src = src; ins_src_zero = zero;
        lat = 0;
        @(negedge clk);
        while (!ins_ready && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = rd_val; ill = illegal; we = csr_we; wa = csr_waddr; wd = csr_wdata;
        @(posedge clk); #1;
        ins_valid = 1'b0; ins_op = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int          lat;
    logic [63:0] rd, wd;
    logic        ill, we;
    logic [11:0] wa;

    initial begin
        clear_from(0);
        for (int i = 0; i < 4096; i++) setcsr(12'(i), 64'(i) * 64'h9E37);
        setcsr(12'h300, 64'h5);   setcsr(12'h304, 64'hAA);  setcsr(12'h305, 64'hF0);
        setcsr(12'h340, 64'hFF);  setcsr(12'hC00, 64'h77);  setcsr(12'h301, 64'h11);
        setcsr(12'h302, 64'h33);  setcsr(12'h306, 64'h10);  setcsr(12'h307, 64'h20);
        setcsr(12'h341, 64'h0);   setcsr(12'h342, 64'h0);

        // Reset state
        #2;
        chk("rst ins_ready", 64'(ins_ready), 64'h0);
        chk("rst csr_we", 64'(csr_we), 64'h0);
        chk("rst csr_raddr", 64'(csr_raddr), 64'h0);
        chk("rst csr_waddr", 64'(csr_waddr), 64'h0);
        chk("rst csr_wdata", csr_wdata, 64'h0);
        chk("rst stall", 64'(stall), 64'h0);
        chk("rst trap_ack", 64'(trap_ack), 64'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // RW write
        issue(2'b01, 12'h300, 64'h8, 1'b0, lat, rd, ill, we, wa, wd);
        chk("t1 latency", 64'(lat), 64'd2);
        chk("t1 rd_val", rd, 64'h5);
        chk("t1 csr_we", 64'(we), 64'h1);
        chk("t1 waddr", 64'(wa), 64'h300);
        chk("t1 wdata", wd, 64'h8);
        chk("t1 illegal", 64'(ill), 64'h0);
        chk("t1 csr300", env_mem[12'h300], 64'h8);

        // RS with zero source: read only
        issue(2'b10, 12'h304, 64'h0, 1'b1, lat, rd, ill, we, wa, wd);
        chk("t2 latency", 64'(lat), 64'd2);
        chk("t2 rd_val", rd, 64'hAA);
        chk("t2 csr_we", 64'(we), 64'h0);

        // RS / RC with real sources
        issue(2'b10, 12'h305, 64'h0F, 1'b0, lat, rd, ill, we, wa, wd);
        chk("t2b wdata", wd, 64'hFF);
        chk("t2b rd_val", rd, 64'hF0);
        issue(2'b11, 12'h340, 64'h0F, 1'b0, lat, rd, ill, we, wa, wd);
        chk("t2c wdata", wd, 64'hF0);
        chk("t2c csr_we", 64'(we), 64'h1);

        // Read-only CSR
        issue(2'b11, 12'hC00, 64'h1, 1'b0, lat, rd, ill, we, wa, wd);
        chk("t3a illegal", 64'(ill), 64'h1);
        chk("t3a csr_we", 64'(we), 64'h0);
        chk("t3a rd_val", rd, 64'h77);
        issue(2'b11, 12'hC00, 64'h0, 1'b1, lat, rd, ill, we, wa, wd);
        chk("t3b illegal", 64'(ill), 64'h0);
        chk("t3b csr_we", 64'(we), 64'h0);
        issue(2'b01, 12'hC01, 64'h0, 1'b1, lat, rd, ill, we, wa, wd);
        chk("t3c illegal", 64'(ill), 64'h1);
        chk("t3c csrC00", env_mem[12'hC00], 64'h77);

        // op 00 is ignored
        @(posedge clk); #1;
        ins_valid = 1'b1; ins_op = 2'b00; ins_addr = 12'h300;
        @(negedge clk);
        chk("op00 stall", 64'(stall), 64'h0);
        @(negedge clk);
        chk("op00 raddr", 64'(csr_raddr), 64'h0);
        @(posedge clk); #1;
        ins_valid = 1'b0;

        // Back-to-back: next instruction accepted at T+3, retires at T+5
        @(posedge clk); #1;
        ins_valid = 1'b1; ins_op = 2'b10; ins_addr = 12'h306; ins_src = 64'h1; ins_src_zero = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("b2b A ready", 64'(ins_ready), 64'h1);
        chk("b2b A wdata", csr_wdata, 64'h11);
        @(posedge clk); #1;
        ins_op = 2'b01; ins_addr = 12'h307; ins_src = 64'h3;
        @(negedge clk);
        chk("b2b B T+3 ready", 64'(ins_ready), 64'h0);
        @(negedge clk);
        chk("b2b B raddr", 64'(csr_raddr), 64'h307);
        @(negedge clk);
        chk("b2b B ready", 64'(ins_ready), 64'h1);
        chk("b2b B rd_val", rd_val, 64'h20);
        @(posedge clk); #1;
        ins_valid = 1'b0; ins_op = 2'b00;

        // Trap and instruction in the same cycle: trap first
        @(posedge clk); #1;
        trap_req = 1'b1; trap_pc = 64'h1000; trap_cause = 64'hB;
        ins_valid = 1'b1; ins_op = 2'b01; ins_addr = 12'h300; ins_src = 64'h1234; ins_src_zero = 1'b0;
        @(negedge clk);
        chk("t4 T stall", 64'(stall), 64'h1);
        @(negedge clk);
        chk("t4 epc we", 64'(csr_we), 64'h1);
        chk("t4 epc waddr", 64'(csr_waddr), 64'h341);
        chk("t4 epc wdata", csr_wdata, 64'h1000);
        @(negedge clk);
        chk("t4 ack", 64'(trap_ack), 64'h1);
        chk("t4 cause waddr", 64'(csr_waddr), 64'h342);
        chk("t4 cause wdata", csr_wdata, 64'hB);
        @(posedge clk); #1;
        trap_req = 1'b0;
        @(negedge clk);
        chk("t4 T+3 ready", 64'(ins_ready), 64'h0);
        @(negedge clk);
        chk("t4 T+4 raddr", 64'(csr_raddr), 64'h300);
        @(negedge clk);
        chk("t4 T+5 ready", 64'(ins_ready), 64'h1);
        chk("t4 T+5 rd_val", rd_val, 64'h8);
        chk("t4 T+5 wdata", csr_wdata, 64'h1234);
        @(posedge clk); #1;
        ins_valid = 1'b0; ins_op = 2'b00;

        // Trap raised during READ waits for the instruction
        @(posedge clk); #1;
        ins_valid = 1'b1; ins_op = 2'b01; ins_addr = 12'h302; ins_src = 64'h22; ins_src_zero = 1'b0;
        @(posedge clk); #1;
        trap_req = 1'b1; trap_pc = 64'h2000; trap_cause = 64'h7;
        @(negedge clk); @(negedge clk);
        chk("t5 ready", 64'(ins_ready), 64'h1);
        chk("t5 rd_val", rd_val, 64'h33);
        chk("t5 ack early", 64'(trap_ack), 64'h0);
        @(posedge clk); #1;
        ins_valid = 1'b0; ins_op = 2'b00;
        @(negedge clk);
        chk("t5 T+3 we", 64'(csr_we), 64'h0);
        @(negedge clk);
        chk("t5 epc waddr", 64'(csr_waddr), 64'h341);
        chk("t5 epc wdata", csr_wdata, 64'h2000);
        @(negedge clk);
        chk("t5 ack", 64'(trap_ack), 64'h1);
        chk("t5 cause wdata", csr_wdata, 64'h7);
        @(posedge clk); #1;
        trap_req = 1'b0;

        // Reset during WRITE cancels the write
        @(posedge clk); #1;
        ins_valid = 1'b1; ins_op = 2'b01; ins_addr = 12'h301; ins_src = 64'h55; ins_src_zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6a pre ready", 64'(ins_ready), 64'h1);
        rst = 1'b1; ins_valid = 1'b0; ins_op = 2'b00;
        #1;
        chk("t6a ready", 64'(ins_ready), 64'h0);
        chk("t6a we", 64'(csr_we), 64'h0);
        chk("t6a rd_val", rd_val, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6a stall", 64'(stall), 64'h0);
        chk("t6a csr301", env_mem[12'h301], 64'h11);

        // Reset during T_EPC: trap abandoned
        @(posedge clk); #1;
        trap_req = 1'b1; trap_pc = 64'h3000; trap_cause = 64'h5;
        @(posedge clk); #1;
        chk("t6b epc we", 64'(csr_we), 64'h1);
        rst = 1'b1; trap_req = 1'b0;
        #1;
        chk("t6b we", 64'(csr_we), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6b no ack", 64'(trap_ack), 64'h0);
            chk("t6b no we", 64'(csr_we), 64'h0);
        end
        chk("t6b mepc", env_mem[12'h341], 64'h2000);
        chk("t6b mcause", env_mem[12'h342], 64'h7);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
